// File: rtl/bus_pkg.sv
// Shared types for the instruction/data bus arbiter: FSM states, port owner,
// and the registered memory-request bundle.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESP     = 2'd3
    } bus_state_e;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_INSTR = 1'b1
    } bus_owner_e;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Fetches are always full-word reads.
    localparam logic [3:0] FETCH_BE = 4'hF;

    function automatic mem_req_t fetch_req(input logic [31:0] addr);
        mem_req_t r;
        r.we    = 1'b0;
        r.be    = FETCH_BE;
        r.addr  = addr;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/bus_prio_sel.sv
// Fixed data-over-instruction priority with a starvation counter that hands
// the bus to the instruction port after STARVE_MAX consecutive losses.
module bus_prio_sel
    import bus_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       i_req,
    input  logic       d_req,
    output bus_owner_e winner,
    output logic       any_req
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          starved;

    always_comb begin
        starved = (cnt_q == CW'(STARVE_MAX));
        any_req = i_req | d_req;
        winner  = (i_req && (!d_req || starved)) ? OWN_INSTR : OWN_DATA;
        cnt_d   = cnt_q;
        if (arb_en) begin
            // Only a real loss by a waiting fetch counts toward starvation.
            if (!i_req || winner == OWN_INSTR)
                cnt_d = '0;
            else if (!starved)
                cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master (fetch/data) to single-port memory arbiter with one outstanding
// transaction; back-to-back issue is possible from the response cycle.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    bus_state_e  state_q, state_d;
    bus_owner_e  owner_q, owner_d;
    logic        m_req_q, m_req_d;
    mem_req_t    mreq_q, mreq_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        arb_en, launch, any_req, accept;
    bus_owner_e  winner;

    bus_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
        .clk     (clk),
        .rst     (rst),
        .arb_en  (arb_en),
        .i_req   (i_req),
        .d_req   (d_req),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_req_d   = m_req_q;
        mreq_d    = mreq_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        arb_en    = 1'b0;
        launch    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                arb_en = 1'b1;
                launch = any_req;
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_req_d = 1'b0;
                    state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                if (m_rvalid) begin
                    if (owner_q == OWN_INSTR) i_rdata_d = m_rdata;
                    else                      d_rdata_d = mreq_q.we ? 32'h0 : m_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                arb_en = 1'b1;
                launch = any_req;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (launch) begin
            state_d = ST_ISSUE;
            m_req_d = 1'b1;
            owner_d = winner;
            if (winner == OWN_INSTR)
                mreq_d = fetch_req(i_addr);
            else
                mreq_d = '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_DATA;
            m_req_q   <= 1'b0;
            mreq_q    <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            m_req_q   <= m_req_d;
            mreq_q    <= mreq_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Grant is combinational so it lines up with the memory accept cycle.
    assign accept   = (state_q == ST_ISSUE) && m_req_q && m_ready;
    assign i_gnt    = accept && (owner_q == OWN_INSTR);
    assign d_gnt    = accept && (owner_q == OWN_DATA);
    assign i_rvalid = (state_q == ST_RESP) && (owner_q == OWN_INSTR);
    assign d_rvalid = (state_q == ST_RESP) && (owner_q == OWN_DATA);
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_req    = m_req_q;
    assign m_we     = mreq_q.we;
    assign m_be     = mreq_q.be;
    assign m_addr   = mreq_q.addr;
    assign m_wdata  = mreq_q.wdata;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: consecutive lost arbitrations after which the instruction port wins.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_req  input  1  instruction-fetch request; held with i_addr until i_gnt.
REQ-005 SHALL have port i_addr  input  32  fetch address.
REQ-006 SHALL have port i_gnt  output  1  one-cycle pulse: fetch accepted by memory.
REQ-007 SHALL have port i_rvalid  output  1  one-cycle pulse: i_rdata valid.
REQ-008 SHALL have port i_rdata  output  32  fetched instruction.
REQ-009 SHALL have port d_req  input  1  data request; held with d_we, d_be, d_addr, d_wdata until d_gnt.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_be  input  4  store byte enables.
REQ-012 SHALL have port d_addr  input  32  data address.
REQ-013 SHALL have port d_wdata  input  32  store data.
REQ-014 SHALL have port d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-015 SHALL have port d_rvalid  output  1  one-cycle pulse: load data valid or store complete.
REQ-016 SHALL have port d_rdata  output  32  load data; 0 for stores.
REQ-017 SHALL have ports m_req/m_we output 1, m_be output 4, m_addr/m_wdata output 32: registered single-port memory request.
REQ-018 SHALL have port m_ready  input  1  memory accepts request when m_req & m_ready.
REQ-019 SHALL have ports m_rvalid input 1, m_rdata input 32: memory response, one per accepted request.
REQ-020 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-021 SHALL implement FSM IDLE, ISSUE, WAIT_RSP, RESP; at most one outstanding memory transaction.
REQ-022 IDLE: if any request, arbitrate, latch the winner's fields into m_* registers, record owner, go ISSUE; else stay.
REQ-023 Arbitration: data wins over instruction unless starve counter == STARVE_MAX and i_req, then instruction wins.
REQ-024 Starve counter: increments (saturating at STARVE_MAX) when i_req loses to d_req; clears when instruction wins or i_req is low at arbitration.
REQ-025 ISSUE: m_req = 1; on m_req & m_ready pulse owner's gnt that same cycle, drop m_req next cycle, go WAIT_RSP; else hold all m_* stable.
REQ-026 WAIT_RSP: on m_rvalid register m_rdata into owner's rdata, go RESP.
REQ-027 RESP: owner's rvalid = 1 for exactly this cycle; then arbitrate as in IDLE (back-to-back ISSUE) or go IDLE.
REQ-028 Latency: request in IDLE at cycle N -> m_req at N+1; m_rvalid at cycle M -> requester rvalid at M+1.
REQ-029 m_rvalid outside WAIT_RSP SHALL be ignored.
REQ-030 Requests arriving while busy SHALL wait; non-owner gnt/rvalid SHALL stay 0.
REQ-031 Simultaneous i_req and d_req in IDLE or RESP SHALL resolve by REQ-023 only.
REQ-032 i_rdata/d_rdata SHALL hold their last value until the next response to that port.

Reset
REQ-033 rst SHALL force IDLE, starve counter 0, owner data, all outputs 0 (including rdata) immediately, regardless of state.
REQ-034 Reset mid-transaction SHALL abandon the transaction; a later m_rvalid for it is ignored per REQ-029.

Structure
REQ-035 FSM state encoding and owner enum SHALL live in shared package bus_pkg.
REQ-036 Arbitration plus starve counter SHALL be one sub-module, bus_prio_sel; FSM and datapath stay in bus_arbiter.

Verification
REQ-037 Single fetch: i_req, i_addr=0x0000_0010, m_ready=1, m_rvalid two cycles after grant with 0x0000_0093 -> m_req at N+1, i_gnt one pulse, i_rvalid with i_rdata=0x0000_0093.
REQ-038 Store: d_we=1, d_be=4'b0011, d_addr=0x0000_0100, d_wdata=0xDEAD_BEEF -> m_we=1, m_be=4'b0011, m_wdata=0xDEAD_BEEF; d_rvalid pulse with d_rdata=0.
REQ-039 Conflict: i_req and d_req in the same cycle -> data granted first, instruction granted in the RESP-cycle arbitration.
REQ-040 Starvation: i_req held, d_req continuous, STARVE_MAX=4 -> 4 data grants, then an instruction grant, then counter 0.
REQ-041 Backpressure: m_ready low 3 cycles -> m_req and m_addr stable 3 cycles, gnt pulses only on the accept cycle.
REQ-042 Reset mid-operation: rst in WAIT_RSP, then m_rvalid -> busy=0, no rvalid pulse, next request served normally.
